// File: rtl/icache_dm.sv
// Direct-mapped, read-only instruction cache.
// The core side takes a word-aligned PC and returns one 32-bit instruction.
// A miss requests the whole line from memory as a burst, fills the line, and
// then returns the requested word. hit_cnt and miss_cnt feed the core's
// performance counters.
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   from_cpu_inst_req_*           fetch request (valid/addr); to_cpu_inst_req_ready
//   to_cpu_cache_rsp_*            instruction response (valid/data); from_cpu_cache_rsp_ready
//   to_mem_rd_req_*               line refill request (valid/addr); from_mem_rd_req_ready
//   from_mem_rd_rsp_*             refill beats (valid/data/last); to_mem_rd_rsp_ready
//   hit_cnt, miss_cnt             wrapping 32-bit hit and miss counters
module icache_dm #(
  parameter int SETS       = 8,
  parameter int LINE_WORDS = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        from_cpu_inst_req_valid,
  input  logic [31:0] from_cpu_inst_req_addr,
  output logic        to_cpu_inst_req_ready,
  output logic        to_cpu_cache_rsp_valid,
  output logic [31:0] to_cpu_cache_rsp_data,
  input  logic        from_cpu_cache_rsp_ready,
  output logic        to_mem_rd_req_valid,
  output logic [31:0] to_mem_rd_req_addr,
  input  logic        from_mem_rd_req_ready,
  input  logic        from_mem_rd_rsp_valid,
  input  logic [31:0] from_mem_rd_rsp_data,
  input  logic        from_mem_rd_rsp_last,
  output logic        to_mem_rd_rsp_ready,
  output logic [31:0] hit_cnt,
  output logic [31:0] miss_cnt
);
  localparam int IW = $clog2(SETS);
  localparam int WW = $clog2(LINE_WORDS);
  localparam int OW = WW + 2;
  localparam int TW = 32 - IW - OW;
  localparam int BW = WW + 1;  // beat counter must be able to reach LINE_WORDS

  typedef enum logic [4:0] {
    S_WAIT    = 5'b00001,
    S_TAG_RD  = 5'b00010,
    S_MEM_REQ = 5'b00100,
    S_REFILL  = 5'b01000,
    S_RESP    = 5'b10000
  } state_t;

  state_t state, state_nxt;

  logic [31:0]     req_addr;
  logic [31:0]     rsp_reg;
  logic [BW-1:0]   beat_cnt;
  logic [SETS-1:0] valid;
  logic [TW-1:0]   tag_mem  [SETS];
  logic [31:0]     data_mem [SETS][LINE_WORDS];

  logic [TW-1:0] req_tag;
  logic [IW-1:0] req_idx;
  logic [WW-1:0] req_word;
  logic [WW-1:0] beat_word;
  logic          beat_in_line;
  logic          beat_fire;
  logic          hit;

  assign req_tag      = req_addr[31:IW+OW];
  assign req_idx      = req_addr[IW+OW-1:OW];
  assign req_word     = req_addr[OW-1:2];
  assign beat_word    = beat_cnt[WW-1:0];
  // LINE_WORDS is a power of two, so the top counter bit flags saturation.
  assign beat_in_line = ~beat_cnt[WW];
  assign beat_fire    = (state == S_REFILL) && from_mem_rd_rsp_valid;
  assign hit          = valid[req_idx] && (tag_mem[req_idx] == req_tag);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_WAIT;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    unique case (state)
      S_WAIT:    if (from_cpu_inst_req_valid) state_nxt = S_TAG_RD;
      S_TAG_RD:  state_nxt = hit ? S_RESP : S_MEM_REQ;
      S_MEM_REQ: if (from_mem_rd_req_ready) state_nxt = S_REFILL;
      S_REFILL:  if (from_mem_rd_rsp_valid && from_mem_rd_rsp_last) state_nxt = S_RESP;
      S_RESP:    if (from_cpu_cache_rsp_ready) state_nxt = S_WAIT;
      default:   state_nxt = S_WAIT;
    endcase
  end

  // Outputs decoded from state; req_ready is held low while reset is asserted.
  always_comb begin
    to_cpu_inst_req_ready  = (state == S_WAIT) && !rst;
    to_cpu_cache_rsp_valid = (state == S_RESP);
    to_mem_rd_req_valid    = (state == S_MEM_REQ);
    to_mem_rd_rsp_ready    = (state == S_REFILL);
    to_mem_rd_req_addr     = {req_addr[31:OW], {OW{1'b0}}};
    to_cpu_cache_rsp_data  = rsp_reg;
  end

  // Request/response registers, valid bits, beat counter and statistics
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_addr <= '0;
      rsp_reg  <= '0;
      beat_cnt <= '0;
      valid    <= '0;
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else begin
      unique case (state)
        S_WAIT: if (from_cpu_inst_req_valid) req_addr <= from_cpu_inst_req_addr;
        S_TAG_RD: begin
          if (hit) begin
            rsp_reg <= data_mem[req_idx][req_word];
            hit_cnt <= hit_cnt + 32'd1;
          end else begin
            miss_cnt <= miss_cnt + 32'd1;
          end
        end
        S_MEM_REQ: begin
          beat_cnt       <= '0;
          valid[req_idx] <= 1'b0;
        end
        S_REFILL: begin
          if (from_mem_rd_rsp_valid) begin
            if (beat_in_line) beat_cnt <= beat_cnt + BW'(1);
            if (beat_in_line && (beat_word == req_word)) rsp_reg <= from_mem_rd_rsp_data;
            // The line is valid only if this last beat is exactly beat LINE_WORDS.
            if (from_mem_rd_rsp_last)
              valid[req_idx] <= (beat_cnt == BW'(LINE_WORDS - 1));
          end
        end
        default: ;
      endcase
    end
  end

  // Tag and data arrays, not reset
  always_ff @(posedge clk) begin
    if (beat_fire && beat_in_line) data_mem[req_idx][beat_word] <= from_mem_rd_rsp_data;
    if (beat_fire && from_mem_rd_rsp_last) tag_mem[req_idx] <= req_tag;
  end

endmodule

// File: tb/tb_icache_dm.sv
module tb_icache_dm;
  localparam int SETS = 8;
  localparam int LW   = 8;
  localparam int IW   = 3;
  localparam int OW   = 5;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic [31:0] req_addr = '0;
  logic        req_ready;
  logic        rsp_valid;
  logic [31:0] rsp_data;
  logic        rsp_ready = 1'b0;
  logic        mreq_valid;
  logic [31:0] mreq_addr;
  logic        mreq_ready = 1'b0;
  logic        mrsp_valid = 1'b0;
  logic [31:0] mrsp_data = '0;
  logic        mrsp_last = 1'b0;
  logic        mrsp_ready;
  logic [31:0] hit_cnt, miss_cnt;

  icache_dm #(.SETS(SETS), .LINE_WORDS(LW)) dut (
    .clk                      (clk),
    .rst                      (rst),
    .from_cpu_inst_req_valid  (req_valid),
    .from_cpu_inst_req_addr   (req_addr),
    .to_cpu_inst_req_ready    (req_ready),
    .to_cpu_cache_rsp_valid   (rsp_valid),
    .to_cpu_cache_rsp_data    (rsp_data),
    .from_cpu_cache_rsp_ready (rsp_ready),
    .to_mem_rd_req_valid      (mreq_valid),
    .to_mem_rd_req_addr       (mreq_addr),
    .from_mem_rd_req_ready    (mreq_ready),
    .from_mem_rd_rsp_valid    (mrsp_valid),
    .from_mem_rd_rsp_data     (mrsp_data),
    .from_mem_rd_rsp_last     (mrsp_last),
    .to_mem_rd_rsp_ready      (mrsp_ready),
    .hit_cnt                  (hit_cnt),
    .miss_cnt                 (miss_cnt)
  );

  always #5 clk = ~clk;

  // Reference model: cache contents, last returned word, statistics.
  logic        m_valid [SETS];
  logic [31:0] m_tag   [SETS];
  logic [31:0] m_data  [SETS][LW];
  logic [31:0] m_resp, m_hits, m_misses;

  // Expected handshake outputs for the current cycle.
  logic        e_req_ready, e_rsp_valid, e_mreq_valid, e_mrsp_ready;
  logic [31:0] e_mreq_addr;

  int unsigned passed = 0;
  int unsigned total  = 0;
  bit          cmp_en = 1'b0;
  logic [31:0] seen_maddr;
  logic        h;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("req_ready",  32'(req_ready),  32'(e_req_ready));
      chk("rsp_valid",  32'(rsp_valid),  32'(e_rsp_valid));
      if (e_rsp_valid || rst) chk("rsp_data", rsp_data, m_resp);
      chk("mreq_valid", 32'(mreq_valid), 32'(e_mreq_valid));
      if (e_mreq_valid) chk("mreq_addr", mreq_addr, e_mreq_addr);
      chk("mrsp_ready", 32'(mrsp_ready), 32'(e_mrsp_ready));
      chk("hit_cnt",  hit_cnt,  m_hits);
      chk("miss_cnt", miss_cnt, m_misses);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req_valid = 1'b0; rsp_ready = 1'b0; mreq_ready = 1'b0;
    mrsp_valid = 1'b0; mrsp_last = 1'b0;
    for (int s = 0; s < SETS; s++) m_valid[s] = 1'b0;
    m_hits = '0; m_misses = '0; m_resp = '0;
    e_req_ready = 1'b0; e_rsp_valid = 1'b0; e_mreq_valid = 1'b0; e_mrsp_ready = 1'b0;
    e_mreq_addr = '0;
    step();
    step();
    rst = 1'b0;
    e_req_ready = 1'b1;
    step();
  endtask

  // One fetch. Beat i of a refill carries base+i. abort_after >= 0 asserts
  // reset once that many beats have been delivered.
  task automatic do_req(input logic [31:0] a, input logic [31:0] base, input int nbeats,
                        input int abort_after, input int mstall, input int cstall,
                        input int gapmax, output logic was_hit);
    logic [IW-1:0] idx;
    logic [31:0]   tag;
    int            w;
    bit            aborted;
    idx = a[OW+IW-1:OW];
    tag = a >> (OW + IW);
    w   = int'(a[OW-1:2]);
    aborted = 1'b0;
    req_valid = 1'b1; req_addr = a;
    step();
    req_valid = 1'b0; req_addr = $urandom; e_req_ready = 1'b0;
    step();
    was_hit = m_valid[idx] && (m_tag[idx] == tag);
    if (was_hit) begin
      m_hits++;
      m_resp = m_data[idx][w];
      e_rsp_valid = 1'b1;
    end else begin
      m_misses++;
      e_mreq_valid = 1'b1;
      e_mreq_addr = {a[31:OW], 5'b0};
      seen_maddr = mreq_addr;
      repeat (mstall) step();
      mreq_ready = 1'b1;
      step();
      mreq_ready = 1'b0; e_mreq_valid = 1'b0; e_mrsp_ready = 1'b1;
      m_valid[idx] = 1'b0;
      for (int i = 0; i < nbeats; i++) begin
        if (abort_after == i) begin
          aborted = 1'b1;
          break;
        end
        repeat ($urandom_range(gapmax, 0)) step();
        mrsp_valid = 1'b1; mrsp_data = base + i; mrsp_last = (i == nbeats - 1);
        step();
        mrsp_valid = 1'b0; mrsp_last = 1'b0;
        if (i < LW) m_data[idx][i] = base + i;
        if (i == w) m_resp = base + i;
      end
      if (aborted) begin
        do_reset();
        return;
      end
      m_tag[idx] = tag;
      m_valid[idx] = (nbeats == LW);
      e_mrsp_ready = 1'b0;
      e_rsp_valid = 1'b1;
    end
    repeat (cstall) step();
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0; e_rsp_valid = 1'b0; e_req_ready = 1'b1;
  endtask

  initial begin
    cmp_en = 1'b1;
    do_reset();
    chk("reset_hit_cnt",  hit_cnt,  32'h0);
    chk("reset_miss_cnt", miss_cnt, 32'h0);
    chk("reset_rsp_data", rsp_data, 32'h0);

    // Cold miss
    do_req(32'h10, 32'h1000, 8, -1, 0, 0, 0, h);
    chk("cold_hit",      32'(h),     32'h0);
    chk("cold_maddr",    seen_maddr, 32'h0);
    chk("cold_rsp_data", rsp_data,   32'h1004);
    chk("cold_model",    m_resp,     32'h1004);
    chk("cold_miss_cnt", miss_cnt,   32'h1);
    chk("cold_hit_cnt",  hit_cnt,    32'h0);

    // Hit after fill
    do_req(32'h1C, 32'h0, 8, -1, 0, 0, 0, h);
    chk("hit_flag",     32'(h),   32'h1);
    chk("hit_rsp_data", rsp_data, 32'h1007);
    chk("hit_hit_cnt",  hit_cnt,  32'h1);

    // Conflict eviction in set 0
    do_req(32'h100, 32'h2000, 8, -1, 0, 0, 0, h);
    chk("evict_hit",   32'(h),     32'h0);
    chk("evict_maddr", seen_maddr, 32'h100);
    do_req(32'h0, 32'h1000, 8, -1, 0, 0, 0, h);
    chk("rerequest_hit", 32'(h),   32'h0);
    chk("evict_miss_cnt", miss_cnt, 32'h3);

    // Backpressure on both handshakes
    do_req(32'h48, 32'h3000, 8, -1, 5, 4, 1, h);
    chk("bp_rsp_data", rsp_data, 32'h3002);
    do_req(32'h4C, 32'h0, 8, -1, 0, 4, 0, h);
    chk("bp_hit", 32'(h), 32'h1);
    chk("bp_rsp_data2", rsp_data, 32'h3003);

    // Reset mid-refill
    do_req(32'h64, 32'h4000, 8, 3, 0, 0, 0, h);
    chk("midrst_hit_cnt",  hit_cnt,  32'h0);
    chk("midrst_miss_cnt", miss_cnt, 32'h0);
    chk("midrst_rsp_data", rsp_data, 32'h0);
    do_req(32'h64, 32'h4100, 8, -1, 0, 0, 0, h);
    chk("midrst_refetch_hit", 32'(h), 32'h0);
    chk("midrst_rsp",         rsp_data, 32'h4101);

    // Short burst: word 2 arrives in 4 beats, line stays invalid
    do_req(32'h88, 32'h5000, 4, -1, 0, 0, 0, h);
    chk("short_rsp_data", rsp_data, 32'h5002);
    do_req(32'h88, 32'h5100, 8, -1, 0, 0, 0, h);
    chk("short_next_hit", 32'(h), 32'h0);
    chk("short_refill_rsp", rsp_data, 32'h5102);

    // Randomized traffic over a small address pool to force hits and conflicts
    for (int n = 0; n < 200; n++) begin
      logic [31:0] a;
      int r, nb, ab;
      a = (32'($urandom_range(3, 0)) << 8) | (32'($urandom_range(7, 0)) << 5) |
          (32'($urandom_range(7, 0)) << 2);
      r = $urandom_range(9, 0);
      nb = (r < 7) ? LW : (r == 7) ? $urandom_range(LW - 1, 1) : (r == 8) ? LW + 1 : LW + 2;
      ab = ($urandom_range(24, 0) == 0) ? $urandom_range(nb - 1, 0) : -1;
      do_req(a, $urandom, nb, ab, $urandom_range(3, 0), $urandom_range(3, 0), 2, h);
      if ($urandom_range(3, 0) == 0) step();
    end

    cmp_en = 1'b0;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
